// File: rtl/traversal_scheduler_if.sv
// traversal_scheduler_if: triangle set-up record and scheduler handshake bundle
package traversal_scheduler_pkg;
   typedef struct packed {
      logic [15:0] tri_id;
      logic [15:0] bbox_min_x;
      logic [15:0] bbox_max_x;
      logic [15:0] bbox_min_y;
      logic [15:0] bbox_max_y;
   } triangle_state_t;
endpackage

interface traversal_scheduler_if #(parameter int NUM_UNITS = 4);
   import traversal_scheduler_pkg::*;
   logic                 in_valid;
   triangle_state_t      in_state;
   logic                 in_ready;
   logic                 frame_end;
   logic [NUM_UNITS-1:0] unit_valid;
   triangle_state_t      unit_state;
   logic [NUM_UNITS-1:0] unit_ready;
   logic [NUM_UNITS-1:0] unit_busy;
   logic                 frame_done;
   logic [15:0]          tri_count;
   logic [15:0]          cull_count;
   logic                 busy;
   modport master (output in_valid, in_state, frame_end, unit_ready, unit_busy,
                   input  in_ready, unit_valid, unit_state, frame_done, tri_count, cull_count, busy);
   modport slave  (input  in_valid, in_state, frame_end, unit_ready, unit_busy,
                   output in_ready, unit_valid, unit_state, frame_done, tri_count, cull_count, busy);
endinterface

// File: rtl/traversal_scheduler.sv
// traversal_scheduler: round-robin dispatch of triangles to pixel traversal units with frame drain
module traversal_scheduler
   import traversal_scheduler_pkg::*;
#(
   parameter int NUM_UNITS = 4
) (
   input logic clk,
   input logic rst,
   traversal_scheduler_if.slave bus
);
   localparam int PW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t          state;
   logic            buf_valid;
   triangle_state_t buf_state;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   sel_idx;
   logic            found;
   logic            dispatch;
   logic            accept;
   logic            degen;
   logic [15:0]     tri_count;
   logic [15:0]     cull_count;

   function automatic logic [PW-1:0] wrap(input int v);
      return PW'(v >= NUM_UNITS ? v - NUM_UNITS : v);
   endfunction

   // first ready unit at or after rr_ptr, wrapping around
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      for (int k = 0; k < NUM_UNITS; k++)
         if (!found && bus.unit_ready[wrap(int'(rr_ptr) + k)]) begin
            found   = 1'b1;
            sel_idx = wrap(int'(rr_ptr) + k);
         end
   end

   assign dispatch       = buf_valid && found;
   assign degen          = (bus.in_state.bbox_min_x > bus.in_state.bbox_max_x) ||
                           (bus.in_state.bbox_min_y > bus.in_state.bbox_max_y);
   assign bus.in_ready   = (state == RUN) && (!buf_valid || dispatch);
   assign accept         = bus.in_valid && bus.in_ready;
   assign bus.unit_valid = dispatch ? NUM_UNITS'(1) << sel_idx : '0;
   assign bus.unit_state = buf_state;
   assign bus.frame_done = state == DONE;
   assign bus.tri_count  = tri_count;
   assign bus.cull_count = cull_count;
   assign bus.busy       = !(state == RUN && !buf_valid);

   // buffer, round-robin pointer, saturating counters and frame FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         buf_valid  <= 1'b0;
         buf_state  <= '0;
         rr_ptr     <= '0;
         tri_count  <= '0;
         cull_count <= '0;
      end else begin
         buf_valid  <= (accept && !degen) ? 1'b1 : dispatch ? 1'b0 : buf_valid;
         buf_state  <= (accept && !degen) ? bus.in_state : buf_state;
         rr_ptr     <= !dispatch ? rr_ptr : (sel_idx == PW'(NUM_UNITS - 1)) ? '0 : sel_idx + PW'(1);
         tri_count  <= (state == DONE) ? '0 : (dispatch && tri_count != 16'hFFFF) ? tri_count + 16'd1 : tri_count;
         cull_count <= (state == DONE) ? '0 : (accept && degen && cull_count != 16'hFFFF) ? cull_count + 16'd1 : cull_count;
         case (state)
            RUN:     state <= bus.frame_end ? DRAIN : RUN;
            DRAIN:   state <= (!buf_valid && bus.unit_busy == '0 && &bus.unit_ready) ? DONE : DRAIN;
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_traversal_scheduler.sv
// tb_traversal_scheduler: directed scoreboard bench for traversal_scheduler
module tb_traversal_scheduler;
   import traversal_scheduler_pkg::*;

   typedef struct {
      int id;
      int unit;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   traversal_scheduler_if #(.NUM_UNITS(4)) b();
   traversal_scheduler #(.NUM_UNITS(4)) dut (.clk(clk), .rst(rst), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic triangle_state_t mk_tri(input int id, input int x0 = 0, input int x1 = 5,
                                              input int y0 = 0, input int y1 = 5);
      triangle_state_t t;
      t.tri_id     = 16'(id);
      t.bbox_min_x = 16'(x0);
      t.bbox_max_x = 16'(x1);
      t.bbox_min_y = 16'(y0);
      t.bbox_max_y = 16'(y1);
      return t;
   endfunction

   task automatic drive(input triangle_state_t t, input int unit, input bit fe);
      exp_t e;
      b.in_valid  = 1'b1;
      b.in_state  = t;
      b.frame_end = fe;
      if (unit >= 0) begin
         e.id   = int'(t.tri_id);
         e.unit = unit;
         q.push_back(e);
      end
      @(negedge clk);
      check("in_ready_accept", 32'(b.in_ready), 1);
      @(posedge clk);
      #1;
      b.in_valid  = 1'b0;
      b.frame_end = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // scoreboard: every completed dispatch must match the oldest expected triangle
   always @(negedge clk) begin
      if (!rst && (b.unit_valid & b.unit_ready) != '0) begin
         check("dispatch_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("dispatch_unit", 32'(b.unit_valid), 32'(1) << e.unit);
            check("dispatch_id", 32'(b.unit_state.tri_id), 32'(e.id));
         end
      end
   end

   initial begin
      int pulses;
      bit after;
      rst          = 1'b1;
      b.in_valid   = 1'b0;
      b.in_state   = '0;
      b.frame_end  = 1'b0;
      b.unit_ready = 4'hF;
      b.unit_busy  = 4'h0;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(b.in_ready), 1);
      check("rst_unit_valid", 32'(b.unit_valid), 0);
      check("rst_tri_count", 32'(b.tri_count), 0);
      check("rst_cull_count", 32'(b.cull_count), 0);
      check("rst_frame_done", 32'(b.frame_done), 0);
      check("rst_busy", 32'(b.busy), 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) drive(mk_tri(i), i % 4, 0);
      idle(2);
      check("b2b_tri_count", 32'(b.tri_count), 8);
      check("b2b_queue_empty", 32'(q.size()), 0);
      check("idle_busy", 32'(b.busy), 0);

      drive(mk_tri(50), 0, 0);
      idle(2);
      b.unit_ready = 4'b1001;
      drive(mk_tri(51), 3, 0);
      idle(2);
      b.unit_ready = 4'b0000;
      drive(mk_tri(52), 0, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_unit_valid", 32'(b.unit_valid), 0);
         check("stall_state", 32'(b.unit_state.tri_id), 52);
         check("stall_in_ready", 32'(b.in_ready), 0);
         @(posedge clk);
         #1;
      end
      b.unit_ready = 4'hF;
      idle(2);
      check("stall_queue_empty", 32'(q.size()), 0);
      check("stall_tri_count", 32'(b.tri_count), 11);

      drive(mk_tri(60, 10, 9), -1, 0);
      idle(2);
      check("cull_x_count", 32'(b.cull_count), 1);
      check("cull_x_tri", 32'(b.tri_count), 11);
      drive(mk_tri(62, 0, 5, 7, 3), -1, 0);
      drive(mk_tri(61, 4, 4, 4, 4), 1, 0);
      idle(2);
      check("cull_y_count", 32'(b.cull_count), 2);
      check("edge_tri_count", 32'(b.tri_count), 12);

      b.unit_busy = 4'b0100;
      drive(mk_tri(70), 2, 1);
      b.in_valid = 1'b1;
      b.in_state = mk_tri(71);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("drain_in_ready", 32'(b.in_ready), 0);
         check("drain_frame_done", 32'(b.frame_done), 0);
         @(posedge clk);
         #1;
         b.frame_end = (k == 3);
      end
      b.in_valid  = 1'b0;
      b.frame_end = 1'b0;
      b.unit_busy = 4'h0;
      pulses = 0;
      after  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (after) begin
            check("post_done_tri", 32'(b.tri_count), 0);
            check("post_done_cull", 32'(b.cull_count), 0);
            after = 1'b0;
         end
         if (b.frame_done) begin
            pulses++;
            check("done_tri_count", 32'(b.tri_count), 13);
            check("done_cull_count", 32'(b.cull_count), 2);
            after = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check("frame_done_pulses", 32'(pulses), 1);
      check("run_in_ready", 32'(b.in_ready), 1);

      b.unit_ready = 4'h0;
      drive(mk_tri(90, 10, 9), -1, 0);
      drive(mk_tri(80), -1, 1);
      @(negedge clk);
      check("pre_rst_busy", 32'(b.busy), 1);
      check("pre_rst_in_ready", 32'(b.in_ready), 0);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      b.unit_ready = 4'hF;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("drain_rst_unit_valid", 32'(b.unit_valid), 0);
      check("drain_rst_in_ready", 32'(b.in_ready), 1);
      check("drain_rst_tri", 32'(b.tri_count), 0);
      check("drain_rst_cull", 32'(b.cull_count), 0);
      check("drain_rst_busy", 32'(b.busy), 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 70000; i++) drive(mk_tri(i & 16'hFFFF), i % 4, 0);
      idle(2);
      check("sat_tri_count", 32'(b.tri_count), 32'hFFFF);
      check("sat_queue_empty", 32'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/traversal_scheduler.md
TRAVERSAL_SCHEDULER -- requirements
Module: traversal_scheduler

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of pixel traversal units served (legal range 1..8).
REQ-002 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream triangle valid.
REQ-005 SHALL have port in_state  input  triangle_state_t  upstream triangle set-up data.
REQ-006 SHALL have port in_ready  output  1  scheduler accepts in_state this cycle.
REQ-007 SHALL have port frame_end  input  1  single-cycle pulse: the last triangle of the frame has been offered.
REQ-008 SHALL have port unit_valid  output  NUM_UNITS  one-hot dispatch valid, one bit per traversal unit.
REQ-009 SHALL have port unit_state  output  triangle_state_t  triangle broadcast to all units.
REQ-010 SHALL have port unit_ready  input  NUM_UNITS  per-unit in_ready.
REQ-011 SHALL have port unit_busy  input  NUM_UNITS  unit (or its downstream) still emitting pixels.
REQ-012 SHALL have port frame_done  output  1  single-cycle pulse: the frame has fully drained.
REQ-013 SHALL have port tri_count  output  16  triangles dispatched in the current frame.
REQ-014 SHALL have port cull_count  output  16  triangles culled in the current frame.
REQ-015 SHALL have port busy  output  1  high in any state other than RUN with the buffer empty.

Function
REQ-016 SHALL hold one triangle in a single-entry buffer (buf_valid, buf_state); unit_state SHALL equal buf_state.
REQ-017 SHALL drive in_ready = (state==RUN) and (!buf_valid or dispatch this cycle); an accept (in_valid & in_ready) SHALL load the buffer on the next edge, giving one cycle of in-to-dispatch latency with no bubble at full throughput.
REQ-018 SHALL treat a triangle as degenerate when bbox_min_x > bbox_max_x or bbox_min_y > bbox_max_y.
REQ-019 SHALL, on accepting a degenerate triangle, not load the buffer and instead increment cull_count.
REQ-020 SHALL, while buf_valid, select the first unit i with unit_ready[i]=1, searching from rr_ptr upward modulo NUM_UNITS, and assert only unit_valid[i]; unit_valid SHALL be all-zero when buf_valid=0 or no unit is ready.
REQ-021 SHALL complete a dispatch on unit_valid[i] & unit_ready[i]: clear buf_valid (unless reloaded the same cycle), set rr_ptr to (i+1) mod NUM_UNITS, and increment tri_count.
REQ-022 SHALL hold buf_state and the unit_valid selection stable while no ready unit exists; rr_ptr SHALL change only on a completed dispatch.
REQ-023 SHALL saturate tri_count and cull_count at 16'hFFFF; no wrap.
REQ-024 SHALL implement the states RUN, DRAIN and DONE.
REQ-025 RUN -> DRAIN on frame_end; a triangle accepted in the same cycle as frame_end SHALL belong to the current frame.
REQ-026 In DRAIN, in_ready SHALL be 0 and buffered triangles SHALL still dispatch.
REQ-027 DRAIN -> DONE when buf_valid=0 and unit_busy=0 and unit_ready is all-ones.
REQ-028 DONE SHALL last exactly one cycle with frame_done=1, clearing tri_count and cull_count on exit to RUN; counters SHALL be readable during DONE.
REQ-029 SHALL ignore frame_end while in DRAIN or DONE.
REQ-030 SHALL, for NUM_UNITS=1, degenerate to a pass-through: rr_ptr is constant 0.

Reset
REQ-031 SHALL on rst, regardless of state: state=RUN, buf_valid=0, rr_ptr=0, tri_count=0, cull_count=0, unit_valid=0, frame_done=0.
REQ-032 SHALL drop an in-flight buffered triangle on rst; in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-033 SHALL be verified by: NUM_UNITS=4, all unit_ready=1, 8 back-to-back triangles -> dispatched to units 0,1,2,3,0,1,2,3 on consecutive cycles; tri_count=8.
REQ-034 SHALL be verified by: rr_ptr=1, unit_ready=4'b1001 -> unit 3 selected, next rr_ptr=0; then unit_ready=0 for 5 cycles -> unit_valid=0 and buf_state stable, in_ready=0.
REQ-035 SHALL be verified by: triangle with bbox_min_x=10, bbox_max_x=9 -> no unit_valid, cull_count=1, tri_count unchanged.
REQ-036 SHALL be verified by: frame_end coincident with a final accept, unit_busy[2]=1 for 20 cycles -> in_ready=0 during drain, frame_done pulses exactly once after unit_busy clears, counters 0 the following cycle.
REQ-037 SHALL be verified by: rst asserted while buf_valid=1 in DRAIN -> next cycle state=RUN, unit_valid=0, counters 0, in_ready=1.
REQ-038 SHALL be verified by: 70000 accepted triangles in one frame -> tri_count holds 16'hFFFF.
